uart_tx_queue: RTL

Byte queue and pacing stage directly upstream of the UART transmitter. It accepts bytes from the system side at any rate into a synchronous FIFO. It presents them one at a time on the transmitter's level-sensitive `uart_en`/`uart_din` pair. Because the transmitter has no busy output, this block enforces full 10-bit frame spacing itself, using the same `CLK_FREQ`/`UART_BPS` arithmetic.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_txq_fifo.sv | 59 +++++
 rtl/uart_tx_queue.sv | 94 +++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants, FSM state type and baud arithmetic for the UART transmit queue.
package uart_pkg;

  localparam int unsigned UART_FRAME_BITS = 10;
  localparam int unsigned UART_EN_SETUP   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    PULSE = 2'd2,
    GAP   = 2'd3
  } uart_txq_state_e;

  function automatic int unsigned bps_cnt(input int unsigned freq, input int unsigned bps);
    return freq / bps;
  endfunction

endpackage

// File: rtl/uart_txq_fifo.sv
// Synchronous byte FIFO with registered read data; occupancy flags come from the level register.
module uart_txq_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [7:0]               wr_data_i,
  input  logic                     pop_i,
  output logic [7:0]               rd_data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic [7:0]    rd_data_q;
  logic          push, pop;

  // A write while full is dropped even if a pop frees a slot in the same cycle.
  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign push    = push_i && !full_o;
  assign pop     = pop_i && !empty_o;

  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rd_data_q <= 8'h00;
    end else begin
      level_q <= level_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + AW'(1);
        rd_data_q <= mem_q[rd_ptr_q];
      end
    end
  end

  assign rd_data_o = rd_data_q;
  assign level_o   = level_q;

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue and frame pacing in front of a busy-less UART transmitter.
// Optional feature: define UART_TXQ_OVF_EN to add the saturating ovf_cnt dropped-write counter.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int UART_BPS = 9600,
  parameter int DEPTH    = 16,
  parameter int EN_HOLD  = 4
) (
  input  logic                   I_clk,
  input  logic                   I_rst,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy,
  output logic                   uart_en,
  output logic [7:0]             uart_din
`ifdef UART_TXQ_OVF_EN
  ,
  output logic [7:0]             ovf_cnt
`endif
);
  localparam int unsigned BPS_CNT    = bps_cnt(CLK_FREQ, UART_BPS);
  localparam int unsigned FRAME_CLKS = UART_FRAME_BITS * BPS_CNT + UART_EN_SETUP;
  localparam logic [23:0] EN_LAST    = 24'(EN_HOLD - 1);
  localparam logic [23:0] GAP_LAST   = 24'(FRAME_CLKS - 2);

  uart_txq_state_e state_q, state_d;
  logic [23:0]     gap_q, gap_d;
  logic            pop;

  assign pop = (state_q == LOAD);

  uart_txq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i     (I_clk),
    .rst_i     (I_rst),
    .push_i    (wr_en),
    .wr_data_i (wr_data),
    .pop_i     (pop),
    .rd_data_o (uart_din),
    .level_o   (level),
    .full_o    (full),
    .empty_o   (empty)
  );

  // Gap counter is 0 in the first PULSE cycle, so leaving GAP at FRAME_CLKS-2
  // puts the next rise of uart_en exactly FRAME_CLKS cycles after this one.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q + 24'd1;
    case (state_q)
      IDLE: begin
        gap_d = gap_q;
        if (!empty) state_d = LOAD;
      end
      LOAD: begin
        gap_d   = '0;
        state_d = PULSE;
      end
      PULSE: if (gap_q == EN_LAST) state_d = GAP;
      GAP: if (gap_q == GAP_LAST) state_d = empty ? IDLE : LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q <= IDLE;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  // Decoded straight from the state register so reset drops it without a clock.
  assign uart_en = (state_q == PULSE);
  assign busy    = (state_q != IDLE);

`ifdef UART_TXQ_OVF_EN
  logic [7:0] ovf_q;

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst)                             ovf_q <= 8'h00;
    else if (wr_en && full && ovf_q != 8'hFF) ovf_q <= ovf_q + 8'd1;
  end

  assign ovf_cnt = ovf_q;
`endif

endmodule
